// File: rtl/bus_arbit_pkg.sv
// Shared definitions for the four-master bus arbiter and its priority search.
// Holds the FSM encoding, master count, select width and the default hold limit.
package bus_arbit_pkg;

   localparam int NUM_M        = 4;
   localparam int SEL_W        = 2;
   localparam int DEF_MAX_HOLD = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Expand a master index into the one-hot grant vector.
   function automatic logic [NUM_M-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
      logic [NUM_M-1:0] onehot;
      onehot      = '0;
      onehot[sel] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/bus_arbit_rr_pick.sv
// Rotating-priority search: the first requester after 'last' wins, wrapping
// around, so 'last' itself is the lowest-priority candidate.
module rr_pick
   import bus_arbit_pkg::*;
(
   input  logic [NUM_M-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] w_cand;

   // Walk from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      found  = 1'b0;
      idx    = last;
      w_cand = last;
      for (int k = NUM_M; k >= 1; k--) begin
         w_cand = last + SEL_W'(k);
         if (req[w_cand]) begin
            found = 1'b1;
            idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/bus_arbit_rr4.sv
// Four-master round-robin arbiter with a hold-time limit that forces handover
// to a waiting master unless the current owner holds its lock bit.
module bus_arbit_rr4
   import bus_arbit_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CNT_W    = 8
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [NUM_M-1:0] M_req,
   input  logic [NUM_M-1:0] M_lock,
   output logic [NUM_M-1:0] M_grt,
   output logic [SEL_W-1:0] Msel,
   output logic             preempt,
   output logic             busy,
   output logic             o_dbg_state,
   output logic [CNT_W-1:0] o_dbg_hold_cnt
);

   localparam logic [CNT_W-1:0] LP_MAX_HOLD = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

   arb_state_e       r_state;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [SEL_W-1:0] r_last;
   logic [NUM_M-1:0] r_grt;
   logic [SEL_W-1:0] r_msel;
   logic             r_preempt;
   logic             r_busy;

   logic [NUM_M-1:0] w_search_req;
   logic             w_found;
   logic [SEL_W-1:0] w_idx;
   logic             w_owner_req;
   logic             w_owner_lock;

   // The owner is masked out so preemption only ever picks another master;
   // when the owner has dropped its request the mask changes nothing.
   assign w_search_req = M_req & ~r_grt;
   assign w_owner_req  = |(M_req & r_grt);
   assign w_owner_lock = |(M_lock & r_grt);

   rr_pick u_rr_pick (
      .req   (w_search_req),
      .last  (r_last),
      .found (w_found),
      .idx   (w_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_hold_cnt <= '0;
         r_last     <= SEL_W'(NUM_M - 1);
         r_grt      <= '0;
         r_msel     <= '0;
         r_preempt  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_preempt <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state    <= ST_GRANT;
                  r_grt      <= sel_to_onehot(w_idx);
                  r_msel     <= w_idx;
                  r_last     <= w_idx;
                  r_hold_cnt <= LP_ONE;
                  r_busy     <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (!w_owner_req) begin
                  if (w_found) begin
                     r_grt      <= sel_to_onehot(w_idx);
                     r_msel     <= w_idx;
                     r_last     <= w_idx;
                     r_hold_cnt <= LP_ONE;
                  end else begin
                     r_state <= ST_IDLE;
                     r_grt   <= '0;
                     r_busy  <= 1'b0;
                  end
               end else if (r_hold_cnt < LP_MAX_HOLD) begin
                  r_hold_cnt <= r_hold_cnt + LP_ONE;
               end else if (w_found && !w_owner_lock) begin
                  r_grt      <= sel_to_onehot(w_idx);
                  r_msel     <= w_idx;
                  r_last     <= w_idx;
                  r_hold_cnt <= LP_ONE;
                  r_preempt  <= 1'b1;
               end
               // Otherwise the owner keeps the bus with the counter parked at the limit.
            end
            default: begin
               r_state <= ST_IDLE;
               r_grt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign M_grt          = r_grt;
   assign Msel           = r_msel;
   assign preempt        = r_preempt;
   assign busy           = r_busy;
   assign o_dbg_state    = r_state;
   assign o_dbg_hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_bus_arbit_rr4.sv
// Bench for bus_arbit_rr4: directed scenario tasks plus a randomized run
// compared against an integer-level model of the arbitration rules.
module tb_bus_arbit_rr4;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] M_req;
   logic [3:0] M_lock;
   logic [3:0] M_grt;
   logic [1:0] Msel;
   logic       preempt;
   logic       busy;
   logic       dbg_state;
   logic [7:0] dbg_hold;

   int n_vec = 0;
   int n_err = 0;

   // Model state: owner -1 means idle.
   int m_owner = -1;
   int m_last  = 3;
   int m_hold  = 0;
   int m_msel  = 0;
   bit m_pre   = 1'b0;

   bus_arbit_rr4 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .M_req          (M_req),
      .M_lock         (M_lock),
      .M_grt          (M_grt),
      .Msel           (Msel),
      .preempt        (preempt),
      .busy           (busy),
      .o_dbg_state    (dbg_state),
      .o_dbg_hold_cnt (dbg_hold)
   );

   always #5 clk = ~clk;

   function automatic int rr_search(input logic [3:0] req, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (req[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_take(input int w);
      m_owner = w;
      m_last  = w;
      m_msel  = w;
      m_hold  = 1;
   endtask

   task automatic model_edge();
      int         w;
      logic [3:0] others;
      if (reset) begin
         m_owner = -1;
         m_last  = 3;
         m_hold  = 0;
         m_msel  = 0;
         m_pre   = 1'b0;
      end else begin
         m_pre = 1'b0;
         if (m_owner < 0) begin
            w = rr_search(M_req, m_last);
            if (w >= 0) model_take(w);
         end else if (!M_req[m_owner]) begin
            w = rr_search(M_req, m_owner);
            if (w >= 0) model_take(w);
            else m_owner = -1;
         end else if (m_hold < MAXH) begin
            m_hold = m_hold + 1;
         end else begin
            others          = M_req;
            others[m_owner] = 1'b0;
            w = rr_search(others, m_owner);
            if (w >= 0 && !M_lock[m_owner]) begin
               model_take(w);
               m_pre = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      M_req  = 4'b0000;
      M_lock = 4'b0000;
      tick();
      reset  = 1'b0;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      M_req  = 4'b1111;
      M_lock = 4'b0000;
      tick();
      n_vec++;
      if ({M_grt, Msel, busy, preempt, dbg_state, dbg_hold} !== {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL reset_state: got grt=%b sel=%b busy=%b pre=%b st=%b hold=%0d, expected 0000/00/0/0/0/0",
                  M_grt, Msel, busy, preempt, dbg_state, dbg_hold);
      end
      tick();
      n_vec++;
      if ({M_grt, Msel, busy} !== {4'b0000, 2'b00, 1'b0}) begin
         n_err++;
         $display("FAIL reset_hold: got grt=%b sel=%b busy=%b, expected 0000/00/0", M_grt, Msel, busy);
      end
      reset = 1'b0;
      tick();
      n_vec++;
      if ({M_grt, Msel, busy} !== {4'b0001, 2'b00, 1'b1}) begin
         n_err++;
         $display("FAIL reset_first_grant: got grt=%b sel=%b busy=%b, expected 0001/00/1", M_grt, Msel, busy);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] oh;
      do_reset();
      M_req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         oh = 4'b0001 << (i % 4);
         tick();
         M_req = 4'b1111;
         n_vec++;
         if ({M_grt, Msel, busy, preempt} !== {oh, 2'(i % 4), 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL rotation_handover[%0d]: got grt=%b sel=%b busy=%b pre=%b, expected %b/%0d/1/0",
                     i, M_grt, Msel, busy, preempt, oh, i % 4);
         end
         tick();
         tick();
         n_vec++;
         if ({M_grt, dbg_hold} !== {oh, 8'd3}) begin
            n_err++;
            $display("FAIL rotation_hold[%0d]: got grt=%b hold=%0d, expected %b/3", i, M_grt, dbg_hold, oh);
         end
         M_req = 4'b1111 & ~oh;
      end
   endtask

   task automatic test_single();
      do_reset();
      M_req = 4'b0100;
      tick();
      n_vec++;
      if ({M_grt, Msel, busy} !== {4'b0100, 2'b10, 1'b1}) begin
         n_err++;
         $display("FAIL single_grant: got grt=%b sel=%b busy=%b, expected 0100/10/1", M_grt, Msel, busy);
      end
      M_req = 4'b0000;
      tick();
      n_vec++;
      if ({M_grt, Msel, busy, dbg_state} !== {4'b0000, 2'b10, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL single_release: got grt=%b sel=%b busy=%b st=%b, expected 0000/10/0/0",
                  M_grt, Msel, busy, dbg_state);
      end
      tick();
      n_vec++;
      if ({M_grt, Msel, busy} !== {4'b0000, 2'b10, 1'b0}) begin
         n_err++;
         $display("FAIL single_idle: got grt=%b sel=%b busy=%b, expected 0000/10/0", M_grt, Msel, busy);
      end
   endtask

   task automatic test_preempt();
      do_reset();
      M_req = 4'b0001;
      tick();
      // A lock bit held by a waiting master must not protect the owner.
      M_req  = 4'b1001;
      M_lock = 4'b1000;
      for (int c = 2; c <= MAXH; c++) begin
         tick();
         n_vec++;
         if ({M_grt, preempt, dbg_hold} !== {4'b0001, 1'b0, 8'(c)}) begin
            n_err++;
            $display("FAIL preempt_hold[%0d]: got grt=%b pre=%b hold=%0d, expected 0001/0/%0d",
                     c, M_grt, preempt, dbg_hold, c);
         end
      end
      tick();
      M_lock = 4'b0000;
      n_vec++;
      if ({M_grt, Msel, preempt, dbg_hold} !== {4'b1000, 2'b11, 1'b1, 8'd1}) begin
         n_err++;
         $display("FAIL preempt_switch: got grt=%b sel=%b pre=%b hold=%0d, expected 1000/11/1/1",
                  M_grt, Msel, preempt, dbg_hold);
      end
      tick();
      n_vec++;
      if ({M_grt, preempt} !== {4'b1000, 1'b0}) begin
         n_err++;
         $display("FAIL preempt_pulse: got grt=%b pre=%b, expected 1000/0", M_grt, preempt);
      end
   endtask

   task automatic test_lock();
      do_reset();
      M_lock = 4'b0001;
      M_req  = 4'b0001;
      tick();
      M_req = 4'b1001;
      for (int c = 2; c <= MAXH; c++) tick();
      for (int c = 0; c < 6; c++) begin
         tick();
         n_vec++;
         if ({M_grt, preempt, dbg_hold} !== {4'b0001, 1'b0, 8'(MAXH)}) begin
            n_err++;
            $display("FAIL lock_keep[%0d]: got grt=%b pre=%b hold=%0d, expected 0001/0/%0d",
                     c, M_grt, preempt, dbg_hold, MAXH);
         end
      end
      M_lock = 4'b0000;
      M_req  = 4'b1000;
      tick();
      n_vec++;
      if ({M_grt, Msel, preempt} !== {4'b1000, 2'b11, 1'b0}) begin
         n_err++;
         $display("FAIL lock_release: got grt=%b sel=%b pre=%b, expected 1000/11/0", M_grt, Msel, preempt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      M_req = 4'b0010;
      tick();
      tick();
      tick();
      n_vec++;
      if ({M_grt, dbg_hold} !== {4'b0010, 8'd3}) begin
         n_err++;
         $display("FAIL midreset_setup: got grt=%b hold=%0d, expected 0010/3", M_grt, dbg_hold);
      end
      reset = 1'b1;
      tick();
      n_vec++;
      if ({M_grt, busy, dbg_hold, Msel} !== {4'b0000, 1'b0, 8'd0, 2'b00}) begin
         n_err++;
         $display("FAIL midreset_drop: got grt=%b busy=%b hold=%0d sel=%b, expected 0000/0/0/00",
                  M_grt, busy, dbg_hold, Msel);
      end
      reset = 1'b0;
      tick();
      n_vec++;
      if ({M_grt, Msel} !== {4'b0010, 2'b01}) begin
         n_err++;
         $display("FAIL midreset_regrant: got grt=%b sel=%b, expected 0010/01", M_grt, Msel);
      end
   endtask

   task automatic test_random();
      logic [3:0] exp_grt;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 79) == 0);
         M_req = 4'($urandom_range(0, 15));
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) M_req[m_owner] = 1'b1;
         M_lock = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         tick();
         exp_grt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
         n_vec++;
         if ({M_grt, Msel, busy, preempt} !== {exp_grt, 2'(m_msel), (m_owner >= 0), m_pre}) begin
            n_err++;
            $display("FAIL random_outputs[%0d]: got grt=%b sel=%b busy=%b pre=%b, expected %b/%0d/%0d/%0d",
                     n, M_grt, Msel, busy, preempt, exp_grt, m_msel, m_owner >= 0, m_pre);
         end
         if (m_owner >= 0) begin
            n_vec++;
            if (dbg_hold !== 8'(m_hold)) begin
               n_err++;
               $display("FAIL random_hold[%0d]: got %0d expected %0d", n, dbg_hold, m_hold);
            end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_single();
      test_preempt();
      test_lock();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bus_arbit_rr4.md
# bus_arbit_rr4

Four-master round-robin bus arbiter with hold-time limit and bus lock. It replaces the two-master fixed-park arbiter when the shared bus grows to four masters. It drives one-hot grants and the master-select code for the bus data/address multiplexer. It guarantees starvation-free access: rotating priority, plus forced handover after a programmable maximum hold time unless the owner asserts lock.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles for one owner before preemption; legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- M_req  input  4  request per master; bit i = master i.
- M_lock  input  4  lock per master; only the current owner's bit is honoured.
- M_grt  output  4  one-hot grant (all zero when idle); registered.
- Msel  output  2  index of current/last owner, for the bus mux; registered.
- preempt  output  1  one-cycle pulse when ownership is taken by the hold-time limit.
- busy  output  1  high whenever any grant is active.

## Operation
- States: IDLE (no grant) and GRANT (one owner). Encoded in the shared package.
- Round-robin search: start at (last_owner + 1) mod 4 and wrap; the first master with M_req=1 wins. The owner itself is considered last.
- IDLE:
  - Any M_req → GRANT to the search winner. hold_cnt=1.
  - No M_req → stay IDLE. Msel keeps the last owner.
- GRANT, owner's req=0:
  - Another req present → grant the search winner directly, no idle gap. hold_cnt=1.
  - Otherwise → IDLE. M_grt=0. last_owner=owner.
- GRANT, owner's req=1:
  - Below the limit (hold_cnt < MAX_HOLD) → keep the owner; hold_cnt+1.
  - At the limit (hold_cnt == MAX_HOLD), another master requesting, owner's M_lock=0 → grant the search winner. preempt=1 for that cycle. hold_cnt=1.
  - At the limit and (owner's lock=1 or no other request) → keep the owner; hold_cnt saturates at MAX_HOLD, no wrap.
- The lock only suppresses preemption. It never creates or extends a grant without req.
- Lock bits of non-owners are ignored.
- Exactly one bit of M_grt is high in GRANT. Msel always equals the index of that bit.
- last_owner updates to the new owner on every grant change.

## Timing
- Reset (reset=1 at an edge): state=IDLE, M_grt=0000, Msel=00, preempt=0, busy=0, hold_cnt=0, last_owner=3 (so the first search starts at M0).
- Reset dominates every other input. Asserted mid-grant, it drops M_grt to 0000 on the following edge.
- Latency: M_req sampled at edge n → M_grt/Msel valid after edge n (visible during cycle n+1).
- Deassertion: owner's req low at edge n → its grant is removed after edge n. The next owner's grant appears in the same cycle.
- Simultaneous requests: resolved solely by round-robin order; no fixed priority after the first grant.
- preempt is high for exactly the cycle in which the new grant first appears.
- Ownership is never more than MAX_HOLD cycles while another master waits, unless locked.

## Structure
- Shared package bus_arbit_pkg:
  - state encoding (ST_IDLE, ST_GRANT)
  - NUM_M=4
  - SEL_W=2
  - default MAX_HOLD constant
- Sub-module rr_pick: combinational. Inputs: req[3:0], last[1:0]. Outputs: found, idx[1:0]. It is the rotating-priority search, reused by future slave-side schedulers.
- Top level holds the state register, hold counter, last_owner, and registered outputs.

## Test plan
- Reset: apply reset=1 for 2 cycles with M_req=1111 → M_grt=0000, Msel=00, busy=0. Release with M_req=1111 → next cycle M_grt=0001, Msel=00.
- Rotation: M_req=1111, each owner drops its req for one cycle after 3 grant cycles → grants go 0001→0010→0100→1000→0001, with no idle cycle between.
- Single requester: M_req=0100 from IDLE → M_grt=0100, Msel=10 after one cycle. Drop req → M_grt=0000, Msel stays 10, busy=0.
- Preemption (MAX_HOLD=4): M0 holds req, M3 requests at cycle 1 → M0 granted 4 cycles, then M_grt=1000 with preempt=1 for one cycle.
- Lock: same as preemption test but M_lock=0001 → M0 keeps the grant indefinitely, hold_cnt stays at 4, preempt never fires. Drop M_lock and M_req[0] → M3 granted next cycle.
- Reset mid-operation: assert reset while M_grt=0010 with hold_cnt=3 → after the edge, M_grt=0000, hold_cnt=0. After release with M_req=0010, M1 is regranted first (last_owner reset to 3).
